uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8-bit receptor. Adds configurable data width,
//  bit period, stop-bit count, parity error and overrun flags, and start-bit glitch rejection.
//  Sits between the RxD pin and the host register interface, which drains it via rdrf/rdrf_clr.
// PARAMETERS
//  CLK_DIV    16  clk cycles per bit period; legal range 4..65535
//  DATA_BITS  8   data bits per frame; legal range 5..9
//  STOP_BITS  1   stop bits checked; legal values 1 or 2
// PORTS
//  clk       in   1          system clock; all logic on rising edge
//  reset     in   1          asynchronous, active-high reset
//  RxD       in   1          serial line, asynchronous, idle high
//  rdrf_clr  in   1          host pulse that clears rdrf
//  parity    in   2          00 none, 01 even, 10 odd, 11 none (reserved)
//  rx_data   out  DATA_BITS  last received word, LSB = first bit on the line
//  rdrf      out  1          receive data register full
//  FE        out  1          framing error of last loaded frame
//  PE        out  1          parity error of last loaded frame
//  OE        out  1          overrun: last load overwrote an unread word
// BEHAVIOUR
//  - Reset values: rx_data=0, rdrf=0, FE=0, PE=0, OE=0, state IDLE, counters 0, sync FFs=1.
//  - Reset asserted mid-frame aborts the frame. Sync FFs reset to 1, so there is no false start on release.
//  - RxD passes through a 2-FF synchronizer (rxd_s); 2 clk latency. No other logic sees raw RxD.
//  - Bit counter is $clog2(CLK_DIV) bits wide and wraps to 0 at CLK_DIV-1.
//  - FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
//  - IDLE: when rxd_s==0, go to START with counter=0. Parity mode is latched here and held for the whole frame.
//  - START: at counter==CLK_DIV/2-1 sample the line.
//    - Low: go to DATA with counter=0; all later samples fall CLK_DIV apart.
//    - High (glitch): go to IDLE; no flag changes.
//  - DATA: shift in DATA_BITS samples, LSB first.
//    - Then go to PAR if the latched parity is 01/10, else to STOP.
//  - PAR: sample one bit.
//    - Even: PE = bit != ^data.
//    - Odd: PE = bit != ~^data.
//  - STOP: sample STOP_BITS bits; FE=1 if any of them is 0. At the last stop sample (the load cycle):
//    - rx_data<=shift reg, rdrf<=1, FE/PE updated; flags hold until the next load.
//    - OE<=1 if rdrf==1 and rdrf_clr==0 in the load cycle, else OE<=0. New data always overwrites.
//    - Next state: BREAK if FE, else IDLE.
//  - BREAK: wait for rxd_s==1, then go to IDLE. A held-low line produces exactly one FE frame.
//  - rdrf_clr with no load: rdrf<=0 next clk. rdrf_clr in the load cycle: load wins (rdrf=1, OE=0).
//  - rdrf_clr does not touch FE/PE/OE or rx_data.
//  - Load latency: start falling edge + 2 + (DATA_BITS+P+STOP_BITS+0.5)*CLK_DIV clk (+/-1), where P=1 with parity.
//  - Back-to-back frames with no idle gap are accepted. IDLE is re-entered before the next start edge.
// CONFIGURATION
//  - UART_RX_MAJORITY_EN defined:
//    - Each sample (start, data, parity, stop) is the 2-of-3 majority of rxd_s at counter mid-1, mid, mid+1.
//    - Start validation uses the same vote. A 1-clk glitch at mid never flips a bit.
//  - Undefined: single sample of rxd_s at counter mid. Latency is identical in both builds.
// TESTING (CLK_DIV=8, DATA_BITS=8, STOP_BITS=1 unless stated)
//  - No parity: send bits 1,1,0,1,0,1,0,1 (0xAB), stop 1 -> rx_data=0xAB, rdrf=1, FE=PE=OE=0;
//    rdrf_clr pulse -> rdrf=0.
//  - parity=01, 0xAB + parity bit 1 -> PE=0; repeat with parity bit 0 -> PE=1, rx_data=0xAB.
//    parity=10 + bit 0 -> PE=0.
//  - 0x55 with stop bit 0, line then held low 40 clk -> one load, FE=1, rdrf=1;
//    no second rdrf until line high and a new frame arrives.
//  - Two frames 0x11 then 0x22, no rdrf_clr -> OE=1, rx_data=0x22.
//    Repeat with rdrf_clr in the second load cycle -> OE=0, rdrf=1.
//  - 2-clk low glitch on idle RxD -> no rdrf, FSM back to IDLE.
//    Reset asserted mid-frame of 0x3C -> all outputs 0 immediately; next clean frame 0x5A -> rx_data=0x5A.
//  - DATA_BITS=7, STOP_BITS=2, parity=10: 0x41 + parity 1 -> rx_data=0x41, PE=0;
//    second stop bit 0 -> FE=1. Run once with and once without UART_RX_MAJORITY_EN.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with parity, framing and overrun flags.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the bit centre.
module uart_rx_param #(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 RxD,
   input  logic                 rdrf_clr,
   input  logic [1:0]           parity,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rdrf,
   output logic                 FE,
   output logic                 PE,
   output logic                 OE
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] MID = CW'(CLK_DIV / 2 - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;
   state_t state;
   logic rxd_m, rxd_s, smp, tick, sidx, pe_p, fe_p;
   logic [CW-1:0] cnt;
   logic [3:0] bidx;
   logic [1:0] pmode;
   logic [DATA_BITS-1:0] sh;
`ifdef UART_RX_MAJORITY_EN
   logic rxd_p;
   always_ff @(posedge clk or posedge reset)
      if (reset) rxd_p <= 1'b1;
      else rxd_p <= rxd_s;
   // rxd_m already holds what rxd_s shows one clk later, so the vote adds no latency
   assign smp = (rxd_p & rxd_s) | (rxd_p & rxd_m) | (rxd_s & rxd_m);
`else
   assign smp = rxd_s;
`endif
   assign tick = cnt == LAST;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         rxd_m   <= 1'b1;
         rxd_s   <= 1'b1;
         cnt     <= '0;
         bidx    <= '0;
         sidx    <= 1'b0;
         pe_p    <= 1'b0;
         fe_p    <= 1'b0;
         pmode   <= '0;
         sh      <= '0;
         rx_data <= '0;
         rdrf    <= 1'b0;
         FE      <= 1'b0;
         PE      <= 1'b0;
         OE      <= 1'b0;
      end else begin
         rxd_m <= RxD;
         rxd_s <= rxd_m;
         cnt   <= tick ? '0 : cnt + CW'(1);
         if (rdrf_clr) rdrf <= 1'b0;
         case (state)
            IDLE: begin
               cnt   <= '0;
               bidx  <= '0;
               sidx  <= 1'b0;
               pe_p  <= 1'b0;
               fe_p  <= 1'b0;
               pmode <= parity;
               if (!rxd_s) state <= START;
            end
            START: if (cnt == MID) begin
               cnt   <= '0;
               state <= smp ? IDLE : DATA;
            end
            DATA: if (tick) begin
               sh   <= {smp, sh[DATA_BITS-1:1]};
               bidx <= bidx + 4'd1;
               if (bidx == 4'(DATA_BITS - 1))
                  state <= (pmode == 2'b01 || pmode == 2'b10) ? PAR : STOP;
            end
            PAR: if (tick) begin
               pe_p  <= smp ^ (^sh) ^ pmode[1];
               state <= STOP;
            end
            STOP: if (tick) begin
               if (sidx == 1'(STOP_BITS - 1)) begin
                  rx_data <= sh;
                  rdrf    <= 1'b1;
                  FE      <= fe_p | ~smp;
                  PE      <= pe_p;
                  OE      <= rdrf & ~rdrf_clr;
                  state   <= (fe_p | ~smp) ? BREAK : IDLE;
               end else begin
                  fe_p <= fe_p | ~smp;
                  sidx <= 1'b1;
               end
            end
            BREAK: if (rxd_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param (8N1 and 7-bit/2-stop instances, CLK_DIV=8).
module tb_uart_rx_param;
   localparam int CD = 8;
   typedef struct packed {logic [8:0] d; logic fe, pe, oe;} exp_t;
   logic clk = 0, reset = 1;
   logic rxd0 = 1, clr0 = 0, rxd1 = 1, clr1 = 0;
   logic [1:0] par0 = 0, par1 = 0;
   logic [7:0] dat0;
   logic [6:0] dat1;
   logic rdrf0, fe0, pe0, oe0, rdrf1, fe1, pe1, oe1;
   int checks = 0, errors = 0;
   bit full0 = 0, full1 = 0;
   exp_t q0[$], q1[$];
   exp_t e0, e1;
   logic p_r0 = 0, p_r1 = 0;
   logic [7:0] p_d0 = 0;
   logic [6:0] p_d1 = 0;

   uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset), .RxD(rxd0), .rdrf_clr(clr0), .parity(par0),
      .rx_data(dat0), .rdrf(rdrf0), .FE(fe0), .PE(pe0), .OE(oe0));
   uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(7), .STOP_BITS(2)) u1 (
      .clk(clk), .reset(reset), .RxD(rxd1), .rdrf_clr(clr1), .parity(par1),
      .rx_data(dat1), .rdrf(rdrf1), .FE(fe1), .PE(pe1), .OE(oe1));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
      end
   endtask

   // Monitor: a load shows as rdrf rising, or new data arriving while rdrf is still set
   always @(negedge clk) begin
      if (!reset && rdrf0 && (!p_r0 || dat0 != p_d0)) begin
         chk("u0 load expected", q0.size() > 0, 1);
         if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("u0 rx_data", dat0, e0.d);
            chk("u0 FE", fe0, e0.fe);
            chk("u0 PE", pe0, e0.pe);
            chk("u0 OE", oe0, e0.oe);
         end
      end
      if (!reset && rdrf1 && (!p_r1 || dat1 != p_d1)) begin
         chk("u1 load expected", q1.size() > 0, 1);
         if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("u1 rx_data", dat1, e1.d);
            chk("u1 FE", fe1, e1.fe);
            chk("u1 PE", pe1, e1.pe);
            chk("u1 OE", oe1, e1.oe);
         end
      end
      p_r0 = rdrf0; p_d0 = dat0; p_r1 = rdrf1; p_d1 = dat1;
   end

   // Drive one frame; the expected result comes from the frame contents and the host-full flag
   task automatic send(input int w, input logic [8:0] d, input logic [1:0] pm, input logic pb,
                       input logic [1:0] st, input int gap, input bit clr_ld = 0,
                       input bit gl = 0, input int trunc = 0);
      int nb = w ? 7 : 8;
      int ns = w ? 2 : 1;
      logic b[$];
      logic [8:0] dm;
      logic v, k;
      exp_t e;
      dm = d & ((9'd1 << nb) - 9'd1);
      b.push_back(1'b0);
      for (int i = 0; i < nb; i++) b.push_back(dm[i]);
      if (pm == 2'b01 || pm == 2'b10) b.push_back(pb);
      for (int i = 0; i < ns; i++) b.push_back(st[i]);
      if (trunc == 0) begin
         e.d = dm;
         e.fe = 1'b0;
         for (int i = 0; i < ns; i++) e.fe = e.fe | ~st[i];
         e.pe = (pm == 2'b01) ? (pb != ^dm) : (pm == 2'b10) ? (pb == ^dm) : 1'b0;
         e.oe = (w ? full1 : full0) && !clr_ld;
         if (w) begin full1 = 1; q1.push_back(e); end
         else begin full0 = 1; q0.push_back(e); end
      end else
         while (b.size() > trunc) void'(b.pop_back());
      if (w) par1 = pm; else par0 = pm;
      foreach (b[j])
         for (int c = 0; c < CD; c++) begin
            @(negedge clk);
            v = (gl && c == CD / 2) ? ~b[j] : b[j];
            k = clr_ld && j == b.size() - 1 && c == CD / 2 + 2;
            if (w) begin rxd1 = v; clr1 = k; end
            else begin rxd0 = v; clr0 = k; end
         end
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         if (w) rxd1 = 1; else rxd0 = 1;
      end
   endtask

   task automatic clear(input int w);
      @(negedge clk);
      if (w) clr1 = 1; else clr0 = 1;
      @(negedge clk);
      clr0 = 0; clr1 = 0;
      if (w) full1 = 0; else full0 = 0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 0;
      chk("reset rx_data", dat0, 0);
      chk("reset rdrf", rdrf0, 0);
      chk("reset FE", fe0, 0);
      chk("reset PE", pe0, 0);
      chk("reset OE", oe0, 0);
      chk("reset u1 rdrf", rdrf1, 0);
      repeat (4) @(negedge clk);
      send(0, 9'hAB, 2'b00, 0, 2'b11, 4);
      chk("rdrf after 0xAB", rdrf0, 1);
      clear(0);
      chk("rdrf after clr", rdrf0, 0);
      send(0, 9'hAB, 2'b01, 1, 2'b11, 4); clear(0);
      send(0, 9'hAB, 2'b01, 0, 2'b11, 4); clear(0);
      send(0, 9'hAB, 2'b10, 0, 2'b11, 4); clear(0);
      send(0, 9'h55, 2'b00, 0, 2'b00, 0);
      repeat (40) @(negedge clk);
      chk("rdrf after break frame", rdrf0, 1);
      clear(0);
      repeat (20) @(negedge clk);
      chk("no reload while low", rdrf0, 0);
      rxd0 = 1;
      repeat (8) @(negedge clk);
      send(0, 9'h66, 2'b00, 0, 2'b11, 4); clear(0);
      send(0, 9'h11, 2'b00, 0, 2'b11, 0);
      send(0, 9'h22, 2'b00, 0, 2'b11, 4); clear(0);
      send(0, 9'h11, 2'b00, 0, 2'b11, 0);
      send(0, 9'h22, 2'b00, 0, 2'b11, 4, 1);
      chk("rdrf after clr in load", rdrf0, 1);
      clear(0);
      @(negedge clk); rxd0 = 0;
      @(negedge clk);
      @(negedge clk); rxd0 = 1;
      repeat (3 * CD) @(negedge clk);
      chk("rdrf after glitch", rdrf0, 0);
      send(0, 9'h99, 2'b00, 0, 2'b11, 4);
      send(0, 9'h3C, 2'b00, 0, 2'b11, 0, 0, 0, 5);
      @(negedge clk);
      reset = 1;
      #1;
      chk("mid-frame reset rdrf", rdrf0, 0);
      chk("mid-frame reset rx_data", dat0, 0);
      chk("mid-frame reset flags", {fe0, pe0, oe0}, 0);
      full0 = 0; full1 = 0;
      repeat (2) @(negedge clk);
      rxd0 = 1; reset = 0;
      repeat (4) @(negedge clk);
      send(0, 9'h5A, 2'b00, 0, 2'b11, 4); clear(0);
      send(1, 9'h41, 2'b10, 1, 2'b11, 4); clear(1);
      send(1, 9'h41, 2'b10, 1, 2'b01, 4); clear(1);
`ifdef UART_RX_MAJORITY_EN
      send(0, 9'hC3, 2'b01, 0, 2'b11, 4, 0, 1); clear(0);
`endif
      for (int i = 0; i < 16; i++) begin
         send(0, 9'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11, 4);
         clear(0);
      end
      for (int i = 0; i < 6; i++) begin
         send(1, 9'($urandom_range(0, 127)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11, 4);
         clear(1);
      end
      repeat (20) @(negedge clk);
      chk("u0 loads outstanding", q0.size(), 0);
      chk("u1 loads outstanding", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
